// File: rtl/reset_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_ctrl_pkg
// Description : Shared definitions for the reset release sequencer: state
//               encodings, status width and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_ctrl_pkg;

    localparam int SEQ_STATE_W = 3;

    // State codes are visible on seq_state, so they are fixed values.
    localparam logic [SEQ_STATE_W-1:0] S_HOLD  = 3'd0;
    localparam logic [SEQ_STATE_W-1:0] S_REL   = 3'd1;
    localparam logic [SEQ_STATE_W-1:0] S_DONE  = 3'd2;
    localparam logic [SEQ_STATE_W-1:0] S_SWRST = 3'd3;
    localparam logic [SEQ_STATE_W-1:0] S_ACK   = 3'd4;

    // Domain index width; a single domain still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : reset_seq_ctrl_pkg
`default_nettype wire

// File: rtl/reset_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_timer
// Description : CNT_W-bit up-counter with synchronous clear, load and enable,
//               plus an equality terminal-compare output.
// Ports       : clk        - system clock
//               resetb     - async active-low reset
//               i_clr      - clear counter to zero (highest priority)
//               i_load     - load i_load_val
//               i_load_val - value to load
//               i_en       - count up by one
//               i_cmp_val  - terminal value
//               o_hit      - counter equals i_cmp_val
// Revision    : 1.0 - initial release
// ============================================================================
module reset_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cmp_val,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Exact equality: the owner clears the counter on every hit, so it never
    // needs to wrap.
    assign o_hit = (r_cnt == i_cmp_val);

endmodule : reset_seq_timer
`default_nettype wire

// File: rtl/reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_ctrl
// Description : Sequences reset release to N_DOM downstream domains. After
//               the chip reset deasserts all domains are held STABLE_CYC
//               cycles, then released one at a time in index order, each
//               after its own programmable delay. A 4-phase software reset
//               handshake re-runs the whole release sequence.
// Ports       : clk        - system clock
//               resetb     - async active-low reset (synchronized upstream)
//               dly_cfg    - per-domain extra delay, field i at [i*CNT_W +: CNT_W]
//               sw_rst_req - software reset request (4-phase level)
//               sw_rst_ack - software reset acknowledge
//               dom_rstb   - per-domain active-low reset
//               rst_done   - all domains released
//               seq_state  - current sequencer state for status readback
// Revision    : 1.0 - initial release
// ============================================================================
module reset_seq_ctrl
    import reset_seq_ctrl_pkg::*;
#(
    parameter int N_DOM      = 4,
    parameter int CNT_W      = 8,
    parameter int STABLE_CYC = 16,
    parameter int HOLD_CYC   = 4
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic [N_DOM*CNT_W-1:0] dly_cfg,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic [N_DOM-1:0]       dom_rstb,
    output logic                   rst_done,
    output logic [2:0]             seq_state
);

    localparam int IDX_W = idx_width(N_DOM);

    localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(N_DOM - 1);
    // The timer starts at zero on the first counted edge, so the terminal
    // value is one less than the number of edges to hold.
    localparam logic [CNT_W-1:0] c_stable_term = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_hold_term   = CNT_W'(HOLD_CYC - 1);

    logic [SEQ_STATE_W-1:0] r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_dly;
    logic                   r_pending;
    logic [N_DOM-1:0]       r_dom_rstb;
    logic                   r_rst_done;
    logic                   r_sw_rst_ack;

    logic [CNT_W-1:0]       w_dly_field [N_DOM];
    logic [IDX_W-1:0]       w_next_idx;
    logic                   w_tmr_clr;
    logic                   w_tmr_en;
    logic [CNT_W-1:0]       w_tmr_cmp;
    logic                   w_tmr_hit;

    // Unpack the flat delay bus into per-domain fields.
    for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dly_field
        assign w_dly_field[gi] = dly_cfg[gi*CNT_W +: CNT_W];
    end

    assign w_next_idx = r_idx + 1'b1;

    // Timer steering: it counts only in the timed states and is cleared on
    // every hit, which coincides with every state or index change.
    always_comb begin
        w_tmr_clr = 1'b1;
        w_tmr_en  = 1'b0;
        w_tmr_cmp = '0;
        case (r_state)
            S_HOLD: begin
                w_tmr_cmp = c_stable_term;
                w_tmr_en  = 1'b1;
                w_tmr_clr = w_tmr_hit;
            end
            S_REL: begin
                w_tmr_cmp = r_dly;
                w_tmr_en  = 1'b1;
                w_tmr_clr = w_tmr_hit;
            end
            S_SWRST: begin
                w_tmr_cmp = c_hold_term;
                w_tmr_en  = 1'b1;
                w_tmr_clr = w_tmr_hit;
            end
            default: begin
                w_tmr_clr = 1'b1;
                w_tmr_en  = 1'b0;
            end
        endcase
    end

    reset_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .resetb    (resetb),
        .i_clr     (w_tmr_clr),
        .i_load    (1'b0),
        .i_load_val({CNT_W{1'b0}}),
        .i_en      (w_tmr_en),
        .i_cmp_val (w_tmr_cmp),
        .o_hit     (w_tmr_hit)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= S_HOLD;
            r_idx        <= '0;
            r_dly        <= '0;
            r_pending    <= 1'b0;
            r_dom_rstb   <= '0;
            r_rst_done   <= 1'b0;
            r_sw_rst_ack <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_dom_rstb   <= '0;
                    r_rst_done   <= 1'b0;
                    r_sw_rst_ack <= 1'b0;
                    if (w_tmr_hit) begin
                        r_state <= S_REL;
                        r_idx   <= '0;
                        r_dly   <= w_dly_field[0];
                    end
                end

                S_REL: begin
                    if (w_tmr_hit) begin
                        r_dom_rstb[r_idx] <= 1'b1;
                        if (r_idx == c_last_idx) begin
                            r_state <= S_DONE;
                            r_idx   <= '0;
                        end else begin
                            // Delay is captured as its wait begins, so later
                            // dly_cfg changes do not disturb this domain.
                            r_idx <= w_next_idx;
                            r_dly <= w_dly_field[w_next_idx];
                        end
                    end
                end

                S_DONE: begin
                    if (r_pending) begin
                        // Sequence re-run for a software request is complete.
                        r_state      <= S_ACK;
                        r_sw_rst_ack <= 1'b1;
                        r_pending    <= 1'b0;
                        r_rst_done   <= 1'b1;
                    end else if (sw_rst_req && !r_sw_rst_ack) begin
                        r_state    <= S_SWRST;
                        r_pending  <= 1'b1;
                        r_dom_rstb <= '0;
                        r_rst_done <= 1'b0;
                    end else begin
                        r_rst_done <= 1'b1;
                    end
                end

                S_SWRST: begin
                    r_dom_rstb <= '0;
                    r_rst_done <= 1'b0;
                    if (w_tmr_hit) begin
                        r_state <= S_REL;
                        r_idx   <= '0;
                        r_dly   <= w_dly_field[0];
                    end
                end

                S_ACK: begin
                    r_rst_done <= 1'b1;
                    if (!sw_rst_req) begin
                        r_sw_rst_ack <= 1'b0;
                        r_state      <= S_DONE;
                    end
                end

                default: begin
                    // Unused codes fall back to a full power-up sequence.
                    r_state      <= S_HOLD;
                    r_idx        <= '0;
                    r_dly        <= '0;
                    r_pending    <= 1'b0;
                    r_dom_rstb   <= '0;
                    r_rst_done   <= 1'b0;
                    r_sw_rst_ack <= 1'b0;
                end
            endcase
        end
    end

    assign dom_rstb   = r_dom_rstb;
    assign rst_done   = r_rst_done;
    assign sw_rst_ack = r_sw_rst_ack;
    assign seq_state  = r_state;

endmodule : reset_seq_ctrl
`default_nettype wire

// File: tb/tb_reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_seq_ctrl
// Description : Self-checking bench for reset_seq_ctrl. Expected release
//               times are computed from the delay list with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq_ctrl;

    localparam int N_DOM      = 4;
    localparam int CNT_W      = 8;
    localparam int STABLE_CYC = 16;
    localparam int HOLD_CYC   = 4;

    logic                   clk = 1'b0;
    logic                   resetb;
    logic [N_DOM*CNT_W-1:0] dly_cfg;
    logic                   sw_rst_req;
    logic                   sw_rst_ack;
    logic [N_DOM-1:0]       dom_rstb;
    logic                   rst_done;
    logic [2:0]             seq_state;

    int errors = 0;
    int checks = 0;
    int dly_m [N_DOM];

    always #5 clk = ~clk;

    reset_seq_ctrl #(
        .N_DOM     (N_DOM),
        .CNT_W     (CNT_W),
        .STABLE_CYC(STABLE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .dly_cfg   (dly_cfg),
        .sw_rst_req(sw_rst_req),
        .sw_rst_ack(sw_rst_ack),
        .dom_rstb  (dom_rstb),
        .rst_done  (rst_done),
        .seq_state (seq_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_field(input int i, input int v);
        dly_m[i] = v;
        dly_cfg[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Edge at which domain i rises when the release phase starts at edge
    // 'base': each domain takes its delay plus one edge after the previous.
    function automatic int rel_edge(input int base, input int i);
        int r = base;
        for (int j = 0; j <= i; j++) r += dly_m[j] + 1;
        return r;
    endfunction

    // Step edges first_t..last_t checking outputs against the model.
    task automatic run_seq(input int first_t, input int last_t, input int base,
                           input bit pending, input bit chg);
        int done_t;
        logic [N_DOM-1:0] exp_dom;
        done_t = rel_edge(base, N_DOM - 1) + 1;
        for (int t = first_t; t <= last_t; t++) begin
            tick();
            exp_dom = '0;
            for (int i = 0; i < N_DOM; i++) exp_dom[i] = (t >= rel_edge(base, i));
            check($sformatf("dom_rstb@%0d", t), 32'(dom_rstb), 32'(exp_dom));
            check($sformatf("rst_done@%0d", t), 32'(rst_done), 32'(t >= done_t));
            check($sformatf("sw_rst_ack@%0d", t), 32'(sw_rst_ack), 32'(pending && (t >= done_t)));
            if (chg && t == rel_edge(base, 1) + 1)
                dly_cfg[2*CNT_W +: CNT_W] = '0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dom"},   32'(dom_rstb),   32'(0));
        check({tag, "_done"},  32'(rst_done),   32'(0));
        check({tag, "_ack"},   32'(sw_rst_ack), 32'(0));
        check({tag, "_state"}, 32'(seq_state), 32'(0));
    endtask

    initial begin
        resetb     = 1'b0;
        sw_rst_req = 1'b0;
        dly_cfg    = '0;
        for (int i = 0; i < N_DOM; i++) set_field(i, 0);
        repeat (3) tick();
        check_reset_values("por");

        // Power-up with zero delays: domains at 17..20, done at 21.
        resetb = 1'b1;
        run_seq(1, rel_edge(STABLE_CYC, N_DOM - 1) + 3, STABLE_CYC, 1'b0, 1'b0);
        check("state_done0", 32'(seq_state), 32'(2));

        // Delays {0,5,0,2}; field 2 is cleared while domain 2 waits.
        resetb = 1'b0;
        tick();
        check_reset_values("rst2");
        set_field(0, 2); set_field(1, 0); set_field(2, 5); set_field(3, 0);
        resetb = 1'b1;
        run_seq(1, 30, STABLE_CYC, 1'b0, 1'b1);
        check("state_done1", 32'(seq_state), 32'(2));
        set_field(2, 5);

        // Software reset handshake re-runs the sequence.
        sw_rst_req = 1'b1;
        run_seq(0, rel_edge(HOLD_CYC, N_DOM - 1) + 4, HOLD_CYC, 1'b1, 1'b0);
        check("state_ack", 32'(seq_state), 32'(4));
        sw_rst_req = 1'b0;
        tick();
        check("ack_drop", 32'(sw_rst_ack), 32'(0));
        check("ack_drop_state", 32'(seq_state), 32'(2));
        check("ack_drop_done", 32'(rst_done), 32'(1));
        repeat (3) begin
            tick();
            check("idle_state", 32'(seq_state), 32'(2));
            check("idle_dom", 32'(dom_rstb), 32'({N_DOM{1'b1}}));
        end

        // Async abort in S_REL after domain 1 released.
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        run_seq(1, rel_edge(STABLE_CYC, 1) + 1, STABLE_CYC, 1'b0, 1'b0);
        #2 resetb = 1'b0;
        #1 check_reset_values("abort_rel");

        // Request held through power-up: ignored until S_DONE, taken once.
        sw_rst_req = 1'b1;
        @(negedge clk);
        resetb = 1'b1;
        run_seq(1, rel_edge(STABLE_CYC, N_DOM - 1), STABLE_CYC, 1'b0, 1'b0);
        run_seq(0, rel_edge(HOLD_CYC, N_DOM - 1) + 3, HOLD_CYC, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            check("hold_ack", 32'(sw_rst_ack), 32'(1));
            check("hold_state", 32'(seq_state), 32'(4));
        end
        sw_rst_req = 1'b0;
        tick();
        check("ack_drop2", 32'(sw_rst_ack), 32'(0));
        check("ack_drop2_state", 32'(seq_state), 32'(2));

        // Reset during a software re-run drops the pending handshake.
        sw_rst_req = 1'b1;
        run_seq(0, 5, HOLD_CYC, 1'b1, 1'b0);
        sw_rst_req = 1'b0;
        #2 resetb = 1'b0;
        #1 check_reset_values("abort_sw");
        @(negedge clk);
        resetb = 1'b1;
        run_seq(1, rel_edge(STABLE_CYC, N_DOM - 1) + 3, STABLE_CYC, 1'b0, 1'b0);
        check("no_stale_ack_state", 32'(seq_state), 32'(2));

        // Randomized delay patterns through software resets.
        repeat (4) begin
            for (int i = 0; i < N_DOM; i++) set_field(i, int'($urandom_range(0, 7)));
            sw_rst_req = 1'b1;
            run_seq(0, rel_edge(HOLD_CYC, N_DOM - 1) + 2, HOLD_CYC, 1'b1, 1'b0);
            sw_rst_req = 1'b0;
            tick();
            check("rnd_ack_drop", 32'(sw_rst_ack), 32'(0));
            check("rnd_done", 32'(rst_done), 32'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reset_seq_ctrl
`default_nettype wire
